triangle_pixel_scanner: RTL and testbench

// - Upstream feeder for the barycentric stage.
// - Accepts one triangle (vertices a, b, c in Q16.16), computes its integer bounding box and

---
 rtl/triangle_pixel_scanner.sv | 193 +++++++++++++++++++
 tb/tb_triangle_pixel_scanner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_pixel_scanner.sv
// rtl/triangle_pixel_scanner.sv - bounding-box raster walker feeding the barycentric stage
//
// Purpose: accepts one triangle (a, b, c in Q16.16), computes its integer
// bounding box, clips it to the screen and emits every pixel of the box in
// raster order (x inner, y outer) as p = (x, y, 1.0) in Q16.16.
//
// Ports:
//   clk_in         system clock, rising edge
//   rst_in         synchronous active-low reset
//   a, b, c        vertices, [0]=x [1]=y [2]=z (z ignored), signed Q16.16
//   tri_valid_in   triangle offered       tri_ready_out  high only in IDLE
//   p              pixel coordinate       p_valid_out    p holds a pixel
//   p_ready_in     downstream takes p     last_out       final pixel of triangle
//   busy_out       not IDLE               done_out       one-cycle scan-complete pulse
module triangle_pixel_scanner #(
    parameter int H_RES = 320,
    parameter int V_RES = 180,
    parameter int FRAC  = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [2:0][31:0] a,
    input  logic [2:0][31:0] b,
    input  logic [2:0][31:0] c,
    input  logic            tri_valid_in,
    output logic            tri_ready_out,
    output logic [2:0][31:0] p,
    output logic            p_valid_out,
    input  logic            p_ready_in,
    output logic            last_out,
    output logic            busy_out,
    output logic            done_out
);

    localparam int IW = 17;
    localparam logic signed [IW-1:0] ZERO = '0;
    localparam logic signed [IW-1:0] ONE  = IW'(1);
    localparam logic signed [IW-1:0] XLIM = IW'(H_RES - 1);
    localparam logic signed [IW-1:0] YLIM = IW'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BBOX, S_CLIP, S_SCAN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [IW-1:0] vx_q [0:2];
    logic signed [IW-1:0] vx_d [0:2];
    logic signed [IW-1:0] vy_q [0:2];
    logic signed [IW-1:0] vy_d [0:2];
    logic signed [IW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [IW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d;

    logic signed [IW-1:0] cxmin, cxmax, cymin, cymax;
    logic                 last_pix;
    logic [31:0]          x_ext, y_ext;

    // z is not needed for coverage generation
    logic unused_z;
    assign unused_z = ^{a[2], b[2], c[2]};

    // Arithmetic shift floors toward -inf, so -0.5 maps to -1
    function automatic logic signed [IW-1:0] to_int(input logic [31:0] v);
        return IW'($signed(v) >>> FRAC);
    endfunction

    function automatic logic signed [IW-1:0] min3(input logic signed [IW-1:0] p0,
                                                  input logic signed [IW-1:0] p1,
                                                  input logic signed [IW-1:0] p2);
        logic signed [IW-1:0] m;
        m = (p0 < p1) ? p0 : p1;
        return (m < p2) ? m : p2;
    endfunction

    function automatic logic signed [IW-1:0] max3(input logic signed [IW-1:0] p0,
                                                  input logic signed [IW-1:0] p1,
                                                  input logic signed [IW-1:0] p2);
        logic signed [IW-1:0] m;
        m = (p0 > p1) ? p0 : p1;
        return (m > p2) ? m : p2;
    endfunction

    assign cxmin = (xmin_q < ZERO) ? ZERO : xmin_q;
    assign cxmax = (xmax_q > XLIM) ? XLIM : xmax_q;
    assign cymin = (ymin_q < ZERO) ? ZERO : ymin_q;
    assign cymax = (ymax_q > YLIM) ? YLIM : ymax_q;

    assign last_pix = (x_q == xmax_q) && (y_q == ymax_q);

    always_comb begin
        state_d = state_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (tri_valid_in) begin
                    vx_d[0] = to_int(a[0]);
                    vx_d[1] = to_int(b[0]);
                    vx_d[2] = to_int(c[0]);
                    vy_d[0] = to_int(a[1]);
                    vy_d[1] = to_int(b[1]);
                    vy_d[2] = to_int(c[1]);
                    state_d = S_BBOX;
                end
            end
            S_BBOX: begin
                xmin_d  = min3(vx_q[0], vx_q[1], vx_q[2]);
                xmax_d  = max3(vx_q[0], vx_q[1], vx_q[2]);
                ymin_d  = min3(vy_q[0], vy_q[1], vy_q[2]);
                ymax_d  = max3(vy_q[0], vy_q[1], vy_q[2]);
                state_d = S_CLIP;
            end
            S_CLIP: begin
                xmin_d = cxmin;
                xmax_d = cxmax;
                ymin_d = cymin;
                ymax_d = cymax;
                x_d    = cxmin;
                y_d    = cymin;
                // A box entirely off one screen edge clips to an inverted range
                if ((cxmin > cxmax) || (cymin > cymax)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (p_ready_in) begin
                    if (last_pix) begin
                        state_d = S_DONE;
                    end else if (x_q == xmax_q) begin
                        x_d = xmin_q;
                        y_d = y_q + ONE;
                    end else begin
                        x_d = x_q + ONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            vx_q    <= '{default: '0};
            vy_q    <= '{default: '0};
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x_ext = {{(32-IW){x_q[IW-1]}}, x_q};
    assign y_ext = {{(32-IW){y_q[IW-1]}}, y_q};

    always_comb begin
        p = '0;
        if (state_q == S_SCAN) begin
            p[0] = x_ext << FRAC;
            p[1] = y_ext << FRAC;
            p[2] = 32'd1 << FRAC;
        end
    end

    assign p_valid_out   = (state_q == S_SCAN);
    assign last_out      = (state_q == S_SCAN) && last_pix;
    assign tri_ready_out = (state_q == S_IDLE);
    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = (state_q == S_DONE);

endmodule

// File: tb/tb_triangle_pixel_scanner.sv
// tb/tb_triangle_pixel_scanner.sv - scoreboard bench for triangle_pixel_scanner
module tb_triangle_pixel_scanner;

    logic             clk = 1'b0;
    logic             rst_in = 1'b0;
    logic [2:0][31:0] a = '0, b = '0, c = '0;
    logic             tri_valid_in = 1'b0;
    logic             tri_ready_out;
    logic [2:0][31:0] p;
    logic             p_valid_out;
    logic             p_ready_in = 1'b1;
    logic             last_out, busy_out, done_out;

    triangle_pixel_scanner dut (
        .clk_in(clk), .rst_in(rst_in),
        .a(a), .b(b), .c(c),
        .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .p(p), .p_valid_out(p_valid_out), .p_ready_in(p_ready_in),
        .last_out(last_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    pix_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   beat_cnt = 0;
    bit   bp_mode = 1'b0;
    bit   pend_done = 1'b0;
    bit   prev_stall = 1'b0;
    logic [2:0][31:0] prev_p;
    logic prev_last;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int floor_px(input int v);
        int q;
        q = v / 65536;
        if (v < 0 && q * 65536 != v) q = q - 1;
        return q;
    endfunction

    // Reference: bounding box of floored coordinates, clipped to 320x180, raster order
    task automatic build_expect(input int ax, input int ay, input int bx, input int by,
                                input int cx, input int cy, output int n);
        int xs[3], ys[3];
        int x0, x1, y0, y1;
        xs[0] = floor_px(ax); xs[1] = floor_px(bx); xs[2] = floor_px(cx);
        ys[0] = floor_px(ay); ys[1] = floor_px(by); ys[2] = floor_px(cy);
        x0 = xs[0]; x1 = xs[0]; y0 = ys[0]; y1 = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < x0) x0 = xs[i];
            if (xs[i] > x1) x1 = xs[i];
            if (ys[i] < y0) y0 = ys[i];
            if (ys[i] > y1) y1 = ys[i];
        end
        if (x0 < 0) x0 = 0;
        if (y0 < 0) y0 = 0;
        if (x1 > 319) x1 = 319;
        if (y1 > 179) y1 = 179;
        n = 0;
        if (x0 <= x1 && y0 <= y1) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    pix_t e;
                    e.x = x; e.y = y; e.last = (x == x1 && y == y1);
                    sbq.push_back(e);
                    n++;
                end
            end
        end
    endtask

    // Downstream ready: changed just after each rising edge
    always @(posedge clk) begin
        #1;
        p_ready_in = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: pops the scoreboard on every beat, checks stall stability and done timing
    always @(negedge clk) begin
        if (!rst_in) begin
            prev_stall = 1'b0;
            pend_done  = 1'b0;
        end else begin
            if (pend_done) begin
                check("done_after_last", done_out, 1);
                pend_done = 1'b0;
            end
            if (done_out) check("done_scoreboard_empty", sbq.size(), 0);
            if (prev_stall) begin
                check("stall_valid_hold", p_valid_out, 1);
                check("stall_p0_hold", p[0], prev_p[0]);
                check("stall_p1_hold", p[1], prev_p[1]);
                check("stall_last_hold", last_out, prev_last);
            end
            if (p_valid_out && p_ready_in) begin
                if (sbq.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    pix_t e;
                    e = sbq.pop_front();
                    check("p_x", p[0], longint'(e.x) * 65536);
                    check("p_y", p[1], longint'(e.y) * 65536);
                    check("p_one", p[2], 65536);
                    check("last", last_out, e.last);
                end
                beat_cnt++;
                if (last_out) pend_done = 1'b1;
            end
            prev_stall = p_valid_out && !p_ready_in;
            prev_p     = p;
            prev_last  = last_out;
        end
    end

    task automatic start_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, output int n);
        int g;
        build_expect(ax, ay, bx, by, cx, cy, n);
        beat_cnt = 0;
        g = 0;
        @(negedge clk);
        while (!tri_ready_out && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_before_accept", tri_ready_out, 1);
        a[0] = 32'(ax); a[1] = 32'(ay); a[2] = $urandom;
        b[0] = 32'(bx); b[1] = 32'(by); b[2] = $urandom;
        c[0] = 32'(cx); c[1] = 32'(cy); c[2] = $urandom;
        tri_valid_in = 1'b1;
        @(posedge clk);
        #1 tri_valid_in = 1'b0;
        @(negedge clk);
        check("busy_bbox", busy_out, 1);
        check("ready_low_bbox", tri_ready_out, 0);
        @(negedge clk);
        check("no_valid_clip", p_valid_out, 0);
        @(negedge clk);
        if (n > 0) check("first_valid_T3", p_valid_out, 1);
        else       check("empty_done_T3", done_out, 1);
    endtask

    task automatic finish_tri(input int n);
        int g;
        g = 0;
        while (!done_out && g < 40 * n + 200) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", done_out, 1);
        check("beat_count", beat_cnt, n);
        @(negedge clk);
        check("ready_after_done", tri_ready_out, 1);
        check("idle_after_done", busy_out, 0);
    endtask

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
        int n;
        start_tri(ax, ay, bx, by, cx, cy, n);
        finish_tri(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset held for two edges
        rst_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_p_valid", p_valid_out, 0);
        check("rst_done", done_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_ready", tri_ready_out, 1);
        check("rst_last", last_out, 0);
        check("rst_p", p, 0);
        @(posedge clk);
        #1 rst_in = 1'b1;

        // Small triangle, no backpressure
        bp_mode = 1'b0;
        run_tri(32'h00020000, 32'h00030000, 32'h00040000, 32'h00030000,
                32'h00020000, 32'h00050000);

        // Clipped on the left edge
        run_tri(-33 * 65536, 95 * 65536, 162 * 65536, 95 * 65536,
                182 * 65536, 143 * 65536);

        // Same small triangle under random backpressure
        bp_mode = 1'b1;
        run_tri(32'h00020000, 32'h00030000, 32'h00040000, 32'h00030000,
                32'h00020000, 32'h00050000);

        // Entirely left of the screen
        bp_mode = 1'b0;
        run_tri(-10 * 65536, 10 * 65536, -5 * 65536, 20 * 65536,
                -1 * 65536, 30 * 65536);

        // Fractional negative coordinates floor toward -inf; single pixel at (0,0)
        run_tri(-32768, -32768, 32768, 16384, 0, 0);

        // Reset during SCAN
        start_tri(10 * 65536, 10 * 65536, 60 * 65536, 10 * 65536,
                  10 * 65536, 40 * 65536, n);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst_p_valid", p_valid_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_ready", tri_ready_out, 1);
        check("midrst_done", done_out, 0);
        sbq.delete();
        @(posedge clk);
        #1 rst_in = 1'b1;

        bp_mode = 1'b1;
        run_tri(5 * 65536 + 1234, 7 * 65536, 9 * 65536, 7 * 65536 + 60000,
                6 * 65536, 10 * 65536 + 5);

        // Random small triangles around and beyond the screen edges
        for (int i = 0; i < 8; i++) begin
            int bx, by;
            int v[6];
            bp_mode = ($urandom_range(0, 1) == 1);
            bx = int'($urandom_range(0, 380)) - 30;
            by = int'($urandom_range(0, 230)) - 25;
            for (int k = 0; k < 6; k++) begin
                v[k] = ((k % 2 == 0 ? bx : by) + int'($urandom_range(0, 12)) - 6) * 65536
                       + int'($urandom_range(0, 65535));
            end
            run_tri(v[0], v[1], v[2], v[3], v[4], v[5]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
